// File: rtl/kamikaze_fetch_pkg.sv
// Shared types and helpers for the kamikaze instruction fetch stage.
package kamikaze_fetch_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StWait} bus_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_entry_t;

   // Opcode quadrant 2'b11 marks a full 32-bit instruction; anything else is RVC.
   function automatic logic is_rvc(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/kamikaze_fetch_fifo.sv
// Prefetch buffer of {addr,data} words; exposes the head entry and the low halfword of head+1.
module kamikaze_fetch_fifo
   import kamikaze_fetch_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            push_i,
   input  fetch_entry_t    push_entry_i,
   input  logic            pop_i,
   output fetch_entry_t    head_o,
   output logic            head_valid_o,
   output logic [15:0]     next_hw_o,
   output logic            next_valid_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = CntW - 1;

   fetch_entry_t    mem_q [Depth];
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic            push_ok;
   logic            pop_ok;

   assign pop_ok  = pop_i && (count_q != '0);
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign push_ok = push_i && ((count_q < CntW'(Depth)) || pop_ok);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
   end

   assign head_o       = mem_q[rd_ptr_q];
   assign next_hw_o    = mem_q[rd_ptr_q + PtrW'(1)].data[15:0];
   assign head_valid_o = count_q != '0;
   assign next_valid_o = count_q > CntW'(1);
   assign count_o      = count_q;

endmodule

// File: rtl/kamikaze_fetch.sv
// Instruction fetch: word bus master, prefetch buffer, RVC realignment and registered decode feed.
module kamikaze_fetch
   import kamikaze_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        is_compressed_instr_o,
   output logic [31:0] pc_o
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   bus_state_e      state_q;
   logic            mem_req_q;
   logic [31:0]     fetch_addr_q;
   logic            drop_q;
   logic            off_q;

   fetch_entry_t    push_entry;
   fetch_entry_t    head;
   logic            head_valid;
   logic            next_valid;
   logic [15:0]     next_hw;
   logic [CntW-1:0] fifo_count;
   logic [CntW-1:0] cnt_after;
   logic            push;
   logic            pop;
   logic            room;
   logic            room_after;

   logic            al_valid;
   logic            al_pop;
   logic            al_off;
   logic [31:0]     al_instr;
   logic [31:0]     al_pc;
   logic            take;

   logic            instr_valid_q;
   logic            is_comp_q;
   logic [31:0]     instr_q;
   logic [31:0]     pc_q;
   logic            unused_redirect_pc0;

   assign unused_redirect_pc0 = redirect_pc_i[0];

   // fetch_addr_q already advanced at grant, so the returning word belongs 4 bytes back.
   assign push_entry = '{addr: fetch_addr_q - 32'd4, data: mem_rdata_i};
   assign push       = (state_q == StWait) && mem_rvalid_i && !drop_q && !redirect_i;
   assign cnt_after  = fifo_count + CntW'(push) - CntW'(pop);
   assign room       = fifo_count < CntW'(FIFO_DEPTH);
   assign room_after = cnt_after < CntW'(FIFO_DEPTH);

   kamikaze_fetch_fifo #(
      .Depth (FIFO_DEPTH),
      .CntW  (CntW)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (redirect_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .head_valid_o (head_valid),
      .next_hw_o    (next_hw),
      .next_valid_o (next_valid),
      .count_o      (fifo_count)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         fetch_addr_q <= {RESET_PC[31:2], 2'b00};
         drop_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (room) begin
                  state_q   <= StReq;
                  mem_req_q <= 1'b1;
               end
            end
            StReq: begin
               if (mem_gnt_i) begin
                  state_q      <= StWait;
                  mem_req_q    <= 1'b0;
                  fetch_addr_q <= fetch_addr_q + 32'd4;
               end
            end
            StWait: begin
               if (mem_rvalid_i) begin
                  drop_q    <= 1'b0;
                  state_q   <= room_after ? StReq : StIdle;
                  mem_req_q <= room_after;
               end
            end
            default: begin
               state_q   <= StIdle;
               mem_req_q <= 1'b0;
            end
         endcase
         if (redirect_i) begin
            fetch_addr_q <= {redirect_pc_i[31:2], 2'b00};
            // A response still in flight belongs to the old stream and must be discarded.
            drop_q <= ((state_q == StWait) && !mem_rvalid_i) ||
                      ((state_q == StReq) && mem_gnt_i);
            if ((state_q == StWait) && mem_rvalid_i) begin
               state_q   <= StReq;
               mem_req_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      al_valid = 1'b0;
      al_pop   = 1'b0;
      al_off   = off_q;
      al_instr = '0;
      al_pc    = head.addr;
      if (head_valid) begin
         if (!off_q) begin
            al_valid = 1'b1;
            if (is_rvc(head.data[15:0])) begin
               al_instr = {16'h0000, head.data[15:0]};
               al_off   = 1'b1;
            end else begin
               al_instr = head.data;
               al_pop   = 1'b1;
            end
         end else begin
            al_pc = head.addr + 32'd2;
            if (is_rvc(head.data[31:16])) begin
               al_valid = 1'b1;
               al_instr = {16'h0000, head.data[31:16]};
               al_pop   = 1'b1;
               al_off   = 1'b0;
            end else if (next_valid) begin
               // Instruction straddles two words; upper half comes from the next entry.
               al_valid = 1'b1;
               al_instr = {next_hw, head.data[31:16]};
               al_pop   = 1'b1;
               al_off   = 1'b1;
            end
         end
      end
   end

   assign take = al_valid && !stall_i && !redirect_i;
   assign pop  = take && al_pop;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         off_q         <= RESET_PC[1];
         instr_valid_q <= 1'b0;
         is_comp_q     <= 1'b0;
         instr_q       <= '0;
         pc_q          <= '0;
      end else if (redirect_i) begin
         off_q         <= redirect_pc_i[1];
         instr_valid_q <= 1'b0;
      end else if (!stall_i) begin
         instr_valid_q <= al_valid;
         if (al_valid) begin
            off_q     <= al_off;
            instr_q   <= al_instr;
            pc_q      <= al_pc;
            is_comp_q <= is_rvc(al_instr[15:0]);
         end
      end
   end

   assign mem_req_o             = mem_req_q;
   assign mem_addr_o            = fetch_addr_q;
   assign instr_o               = instr_q;
   assign instr_valid_o         = instr_valid_q;
   assign is_compressed_instr_o = is_comp_q;
   assign pc_o                  = pc_q;

endmodule

// File: tb/tb_kamikaze_fetch.sv
// Bench for kamikaze_fetch: bus responder plus an instruction-stream reference walked from memory.
module tb_kamikaze_fetch;

   localparam logic [31:0] RstPc = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        is_compressed_instr_o;
   logic [31:0] pc_o;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] mem [256];
   int          gnt_delay = 0;
   int          rv_delay = 1;
   bit          rnd_bus = 1'b0;
   int          stall_pct = 0;

   bit          pend;
   logic [31:0] pend_addr;
   int          gnt_cnt;
   int          rv_cnt;

   logic [31:0] model_pc;
   int          n_acc;
   bit          prev_redirect;
   bit          hold_chk;
   logic [31:0] held_addr;

   kamikaze_fetch #(
      .RESET_PC   (RstPc),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i                 (clk),
      .rst_i                 (rst_i),
      .stall_i               (stall_i),
      .redirect_i            (redirect_i),
      .redirect_pc_i         (redirect_pc_i),
      .mem_req_o             (mem_req_o),
      .mem_addr_o            (mem_addr_o),
      .mem_gnt_i             (mem_gnt_i),
      .mem_rvalid_i          (mem_rvalid_i),
      .mem_rdata_i           (mem_rdata_i),
      .instr_o               (instr_o),
      .instr_valid_o         (instr_valid_o),
      .is_compressed_instr_o (is_compressed_instr_o),
      .pc_o                  (pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem[a[9:2]];
   endfunction

   function automatic logic [15:0] mem16(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a);
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Bus slave: one outstanding request, programmable grant and response latency.
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      pend         = 1'b0;
      gnt_cnt      = 0;
      rv_cnt       = 0;
      forever begin
         @(negedge clk);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (!rst_i) begin
            pend    = 1'b0;
            gnt_cnt = gnt_delay;
         end else if (pend) begin
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_word(pend_addr);
               pend         = 1'b0;
            end else begin
               rv_cnt--;
            end
         end else if (mem_req_o) begin
            if (gnt_cnt == 0) begin
               mem_gnt_i = 1'b1;
               pend      = 1'b1;
               pend_addr = mem_addr_o;
               rv_cnt    = (rnd_bus ? int'($urandom_range(1, 3)) : rv_delay) - 1;
               gnt_cnt   = rnd_bus ? int'($urandom_range(0, 3)) : gnt_delay;
            end else begin
               gnt_cnt--;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called at negedge+1 with this cycle's inputs applied; advances one clock.
   task automatic tick();
      logic [15:0] h0;
      logic [31:0] exp_i;
      int          len;
      if (prev_redirect) chk("valid_after_redirect", 32'(instr_valid_o), 32'd0);
      if (hold_chk && mem_req_o) chk("req_addr_stable", mem_addr_o, held_addr);
      hold_chk  = mem_req_o && !mem_gnt_i && !redirect_i;
      held_addr = mem_addr_o;
      if (instr_valid_o && !stall_i && !redirect_i) begin
         h0 = mem16(model_pc);
         if (h0[1:0] != 2'b11) begin
            exp_i = {16'h0000, h0};
            len   = 2;
         end else begin
            exp_i = {mem16(model_pc + 32'd2), h0};
            len   = 4;
         end
         chk("pc", pc_o, model_pc);
         chk("instr", instr_o, exp_i);
         chk("is_compressed", 32'(is_compressed_instr_o), 32'(len == 2));
         model_pc = model_pc + 32'(len);
         n_acc++;
      end
      if (redirect_i) model_pc = redirect_pc_i & ~32'd1;
      prev_redirect = redirect_i;
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int target, input int budget, input string tag);
      int start;
      start = n_acc;
      for (int i = 0; i < budget && (n_acc - start) < target; i++) begin
         stall_i    = ($urandom_range(0, 99) < stall_pct);
         redirect_i = 1'b0;
         tick();
      end
      chk(tag, 32'((n_acc - start) >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst_i         = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_addr", mem_addr_o, RstPc & ~32'd3);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_is_c", 32'(is_compressed_instr_o), 32'd0);
      rst_i         = 1'b1;
      model_pc      = RstPc & ~32'd1;
      n_acc         = 0;
      prev_redirect = 1'b0;
      hold_chk      = 1'b0;
   endtask

   initial begin
      logic [31:0] snap_instr;
      logic [31:0] snap_pc;
      logic        snap_valid;

      // Plain 32-bit NOP stream on a zero-wait bus.
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
      do_reset();
      run(6, 100, "t1_progress");

      // Packed pairs of compressed instructions.
      for (int i = 0; i < 256; i++) mem[i] = 32'h4501_4501;
      do_reset();
      run(6, 100, "t2_progress");

      // 32-bit instruction straddling a word boundary.
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h4501_0000;
      do_reset();
      run(5, 100, "t3_progress");

      // Redirect while a response is outstanding.
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      rv_delay = 3;
      do_reset();
      run(3, 200, "t4_pre");
      for (int k = 0; k < 50 && !pend; k++) tick();
      chk("t4_wait_gnt", 32'(pend), 32'd1);
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0102;
      tick();
      redirect_i = 1'b0;
      chk("t4_mem_addr", mem_addr_o, 32'h0000_0100);
      run(4, 200, "t4_post");

      // Downstream stall: outputs hold, buffer fills, bus goes quiet.
      for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 7) | 32'h13;
      rv_delay = 1;
      do_reset();
      run(4, 100, "t5_pre");
      snap_instr = instr_o;
      snap_pc    = pc_o;
      snap_valid = instr_valid_o;
      stall_i    = 1'b1;
      repeat (5) tick();
      chk("t5_frozen_instr", instr_o, snap_instr);
      chk("t5_frozen_pc", pc_o, snap_pc);
      chk("t5_frozen_valid", 32'(instr_valid_o), 32'(snap_valid));
      chk("t5_req_stopped", 32'(mem_req_o), 32'd0);
      stall_i = 1'b0;
      run(8, 100, "t5_post");

      // Slow grant and response; address must hold while requesting.
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      gnt_delay = 3;
      rv_delay  = 2;
      do_reset();
      run(10, 400, "t6_progress");

      // Random bus timing, stalls and redirects.
      rnd_bus   = 1'b1;
      stall_pct = 30;
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         stall_i       = ($urandom_range(0, 99) < stall_pct);
         redirect_i    = ($urandom_range(0, 39) == 0);
         redirect_pc_i = $urandom();
         tick();
      end
      redirect_i = 1'b0;
      chk("t7_progress", 32'(n_acc > 20), 32'd1);

      // Fetch address wraps past the top of the address space.
      stall_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFA;
      tick();
      redirect_i = 1'b0;
      run(4, 300, "t7_wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
